serial_round_sequencer: RTL and testbench

Timing master for the bit-serial SHA-256 datapath. It generates the shared bit clock `bclk` and the bit index `counter` consumed by every serial shift/rotate unit. Consumers record on the `bclk` rise and play on the `bclk` fall, both detected by edge detection on `clk`. The block steps one compression job through LOAD (16 schedule words), ROUND (N_ROUNDS words) and FLUSH (1 drain word), with a start/busy/done handshake to the host.

---
 rtl/sha256_seq_pkg.sv | 26 ++
 rtl/serial_round_sequencer_bclk_divider.sv | 43 ++++
 rtl/serial_round_sequencer.sv | 119 +++++++++++
 tb/tb_serial_round_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_seq_pkg.sv
// Shared types and default sizes for the bit-serial SHA-256 sequencer.
package sha256_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_LOAD  = 2'd1,
    SEQ_ROUND = 2'd2,
    SEQ_FLUSH = 2'd3
  } seq_phase_t;

  localparam int SEQ_W_WORD   = 32;
  localparam int SEQ_N_LOAD   = 16;
  localparam int SEQ_N_ROUNDS = 64;

  // Phase that follows the last word of the given phase; FLUSH ends the job.
  function automatic seq_phase_t seq_next_phase(input seq_phase_t p);
    seq_phase_t n;
    case (p)
      SEQ_LOAD:  n = SEQ_ROUND;
      SEQ_ROUND: n = SEQ_FLUSH;
      default:   n = SEQ_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/serial_round_sequencer_bclk_divider.sv
// Bit clock generator: divides clk down to a 50% duty bclk while run is high.
// rise_pulse/fall_pulse flag the clk edge at which bclk is about to toggle.
module bclk_divider
  import sha256_seq_pkg::*;
#(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic hold,
  output logic bclk,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int DW = $clog2(HALF_PERIOD);
  localparam logic [DW-1:0] CNT_LAST = DW'(HALF_PERIOD - 1);

  logic [DW-1:0] div_cnt;
  logic          wrap;

  // A half-phase completes only while running and not frozen.
  assign wrap       = run && !hold && (div_cnt == CNT_LAST);
  assign rise_pulse = wrap && !bclk;
  assign fall_pulse = wrap && bclk;

  // Half-phase counter and bclk toggle; idle parks both at zero.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (!hold) begin
      if (wrap) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/serial_round_sequencer.sv
// Timing master for the bit-serial SHA-256 datapath: drives bclk and the
// bit/word indices through LOAD, ROUND and FLUSH for one compression job.
// Optional build macro SEQ_STALL_EN adds a stall input that freezes the job.
module serial_round_sequencer
  import sha256_seq_pkg::*;
#(
  parameter int W_WORD      = SEQ_W_WORD,
  parameter int N_LOAD      = SEQ_N_LOAD,
  parameter int N_ROUNDS    = SEQ_N_ROUNDS,
  parameter int HALF_PERIOD = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        bclk,
  output logic [$clog2(W_WORD)-1:0]   counter,
  output logic [$clog2(N_ROUNDS)-1:0] word_idx,
  output logic [1:0]                  phase,
  output logic                        word_last
`ifdef SEQ_STALL_EN
  ,
  input  logic                        stall
`endif
);

  // state | meaning
  // IDLE  | waiting for start, bclk parked low
  // LOAD  | N_LOAD schedule words shifted in
  // ROUND | N_ROUNDS compression words
  // FLUSH | one drain word, then done

  localparam int CW   = $clog2(W_WORD);
  localparam int WI_W = $clog2(N_ROUNDS);

  localparam logic [CW-1:0]   BIT_LAST   = CW'(W_WORD - 1);
  localparam logic [WI_W-1:0] LOAD_LAST  = WI_W'(N_LOAD - 1);
  localparam logic [WI_W-1:0] ROUND_LAST = WI_W'(N_ROUNDS - 1);

  seq_phase_t      state;
  logic            hold;
  logic            fall_pulse;
  logic            rise_pulse_unused;
  logic [WI_W-1:0] phase_last;

`ifdef SEQ_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  // Consumers detect the bclk rise themselves; only the fall advances us.
  bclk_divider #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .run        (busy),
    .hold       (hold),
    .bclk       (bclk),
    .rise_pulse (rise_pulse_unused),
    .fall_pulse (fall_pulse)
  );

  assign phase     = state;
  assign word_last = (counter == BIT_LAST);

  // Index of the final word in the current phase.
  always_comb begin
    phase_last = '0;
    case (state)
      SEQ_LOAD:  phase_last = LOAD_LAST;
      SEQ_ROUND: phase_last = ROUND_LAST;
      default:   phase_last = '0;
    endcase
  end

  // Phase FSM with bit/word indices, stepped on each bclk fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEQ_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      counter  <= '0;
      word_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        SEQ_IDLE: begin
          if (start) begin
            state    <= SEQ_LOAD;
            busy     <= 1'b1;
            counter  <= '0;
            word_idx <= '0;
          end
        end
        default: begin
          if (fall_pulse) begin
            counter <= counter + CW'(1);
            if (counter == BIT_LAST) begin
              if (word_idx == phase_last) begin
                word_idx <= '0;
                state    <= seq_next_phase(state);
                if (state == SEQ_FLUSH) begin
                  busy <= 1'b0;
                  done <= 1'b1;
                end
              end else begin
                word_idx <= word_idx + WI_W'(1);
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_round_sequencer.sv
// Self-checking bench: a progress-count model predicts every output each cycle,
// and directed jobs pin the model with hand-computed cycle counts.
module tb_serial_round_sequencer;
  import sha256_seq_pkg::*;

  localparam int HP  = 2;
  localparam int P   = 2 * HP;
  localparam int WW  = 32;
  localparam int NL  = 16;
  localparam int NR  = 64;
  localparam int JOB = (NL + NR + 1) * WW * P;
`ifdef SEQ_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       busy, done, bclk, word_last;
  logic [4:0] counter;
  logic [5:0] word_idx;
  logic [1:0] phase;

  serial_round_sequencer #(
    .W_WORD(WW), .N_LOAD(NL), .N_ROUNDS(NR), .HALF_PERIOD(HP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .bclk      (bclk),
    .counter   (counter),
    .word_idx  (word_idx),
    .phase     (phase),
    .word_last (word_last)
`ifdef SEQ_STALL_EN
    ,
    .stall     (stall)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a job is just a count of un-stalled clk edges since acceptance.
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  bit m_valid = 1'b0;
  int m_a = 0;
  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_busy  = 1'b0;
      m_a     = 0;
      m_valid = 1'b1;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1;
        m_a    = 0;
      end
    end else if (!(STALL_EN && stall)) begin
      m_a++;
      if (m_a == JOB) begin
        m_busy = 1'b0;
        m_a    = 0;
        m_done = 1'b1;
      end
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      int bitn, e_cnt, e_w, e_ph, e_bclk;
      e_cnt = 0; e_w = 0; e_ph = 0; e_bclk = 0;
      if (m_busy) begin
        bitn   = m_a / P;
        e_bclk = ((m_a % P) >= HP) ? 1 : 0;
        e_cnt  = bitn % WW;
        e_w    = bitn / WW;
        if (e_w < NL) e_ph = 1;
        else if (e_w < NL + NR) begin e_ph = 2; e_w = e_w - NL; end
        else begin e_ph = 3; e_w = 0; end
      end
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("bclk", bclk, e_bclk);
      chk("counter", counter, e_cnt);
      chk("word_idx", word_idx, e_w);
      chk("phase", phase, e_ph);
      chk("word_last", word_last, (e_cnt == WW - 1) ? 1 : 0);
    end
  end

  int t0, dur, nstall, rises, ld, rd, fl, first_rise, first_cnt, maxw_ld, maxw_rd, frozen;

  task automatic run_job(input bit rnd_start, input bit rnd_stall, input bit stall7);
    bit prev_b, ok, was_st, did7;
    int st_left, st_cnt;
    prev_b = 0; ok = 0; was_st = 0; did7 = 0; st_left = 0; st_cnt = 0;
    nstall = 0; rises = 0; ld = 0; rd = 0; fl = 0; first_rise = -1; first_cnt = -1;
    maxw_ld = 0; maxw_rd = 0; frozen = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; t0 = cyc;
    for (int k = 0; k < JOB + 3000; k++) begin
      if (done) begin ok = 1; break; end
      if (was_st && bclk && counter == st_cnt) frozen++;
      if (bclk && !prev_b) begin
        rises++;
        if (first_rise < 0) first_rise = cyc - t0;
        if (stall7 && !did7 && phase == 2'd2) begin did7 = 1; st_left = 7; st_cnt = counter; end
      end
      prev_b = bclk;
      if (counter == 5'd1 && first_cnt < 0) first_cnt = cyc - t0;
      case (phase)
        2'd1: begin ld++; if (word_idx > maxw_ld) maxw_ld = word_idx; end
        2'd2: begin rd++; if (word_idx > maxw_rd) maxw_rd = word_idx; end
        2'd3: fl++;
        default: ;
      endcase
      start = rnd_start && phase == 2'd2 && ($urandom_range(0, 99) < 3);
      stall = 1'b0;
      if (STALL_EN && rnd_stall && $urandom_range(0, 99) < 5) stall = 1'b1;
      if (STALL_EN && st_left > 0) begin stall = 1'b1; st_left--; end
      was_st = stall;
      if (stall) nstall++;
      @(negedge clk);
    end
    start = 1'b0;
    stall = 1'b0;
    dur = cyc - t0;
    if (!ok) chk("job_timeout", 0, 1);
  endtask

  initial begin
    int d1, d2, ndone;
    bit ok;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_bclk", bclk, 0);
    chk("rst_phase", phase, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Plain job: pin absolute timing and phase lengths.
    run_job(0, 0, 0);
    chk("job_cycles", dur, 10368);
    chk("bclk_rises", rises, 2592);
    chk("first_rise", first_rise, 2);
    chk("first_count", first_cnt, 4);
    chk("load_cycles", ld, 2048);
    chk("round_cycles", rd, 8192);
    chk("flush_cycles", fl, 128);
    chk("max_word_load", maxw_ld, 15);
    chk("max_word_round", maxw_rd, 63);

    // Random start pulses during ROUND (and random stalls when enabled).
    repeat (3) @(negedge clk);
    run_job(1, 1, 0);
    chk("job_cycles_rnd", dur, 10368 + nstall);

    // One 7-cycle stall inside a bclk high phase.
    if (STALL_EN) begin
      repeat (3) @(negedge clk);
      run_job(0, 0, 1);
      chk("job_cycles_stall7", dur, 10368 + 7);
      chk("stall_frozen", frozen, 7);
    end

    // start held high: back-to-back jobs, done once per job.
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk); t0 = cyc;
    d1 = -1; d2 = -1; ndone = 0;
    for (int k = 0; k < 2 * JOB + 200; k++) begin
      if (done) begin
        ndone++;
        if (ndone == 1) d1 = cyc;
        else begin d2 = cyc; start = 1'b0; break; end
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("held_done_count", ndone, 2);
    chk("held_first_len", d1 - t0, 10368);
    chk("held_gap", d2 - d1, 10369);

    // Reset in ROUND at word 20, then a fresh full job.
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    ok = 0;
    for (int k = 0; k < JOB; k++) begin
      if (phase == 2'd2 && word_idx == 6'd20) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk("reach_word20", 0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_bclk", bclk, 0);
    chk("mid_rst_counter", counter, 0);
    chk("mid_rst_word", word_idx, 0);
    chk("mid_rst_phase", phase, 0);
    rst = 1'b0;
    ndone = 0;
    repeat (200) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no_done_after_rst", ndone, 0);
    run_job(0, 0, 0);
    chk("job_cycles_after_rst", dur, 10368);
    chk("bclk_rises_after_rst", rises, 2592);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
